acondicionador_botones: RTL and testbench
=========================================

ACONDICIONADOR_BOTONES -- requirements
Module: acondicionador_botones

Interface
REQ-001 The block SHALL have parameter N_BOTONES, default 3, the number of independent push-button channels (bit 0 selector, bit 1 start, bit 2 reset).
REQ-002 The block SHALL have parameter DEBOUNCE_CICLOS, default 50000, the consecutive stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 botones_n  input  N_BOTONES  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 nivel  output  N_BOTONES  debounced level per channel, 1 = pressed.
REQ-008 pulso_presion  output  N_BOTONES  one-cycle pulse per accepted press.
REQ-009 pulso_liberacion  output  N_BOTONES  one-cycle pulse per accepted release.

Function
REQ-010 Each channel SHALL pass botones_n through a 2-flop synchronizer before any other logic; the synchronized value is s[i].
REQ-011 Each channel SHALL own an independent FSM with states SUELTO, CONFIRMA_PRESION, PRESIONADO, CONFIRMA_LIBERACION and an independent counter of width ceil(log2(DEBOUNCE_CICLOS))+1.
REQ-012 SUELTO: s[i]=0 -> CONFIRMA_PRESION, counter=1; else stay, counter=0.
REQ-013 CONFIRMA_PRESION: s[i]=1 -> SUELTO, counter=0 (bounce rejected); s[i]=0 and counter=DEBOUNCE_CICLOS-1 -> PRESIONADO, counter=0; else counter+1.
REQ-014 PRESIONADO: s[i]=1 -> CONFIRMA_LIBERACION, counter=1; else stay.
REQ-015 CONFIRMA_LIBERACION: s[i]=0 -> PRESIONADO, counter=0; s[i]=1 and counter=DEBOUNCE_CICLOS-1 -> SUELTO, counter=0; else counter+1.
REQ-016 nivel[i] SHALL be registered, 1 exactly while FSM is PRESIONADO or CONFIRMA_LIBERACION.
REQ-017 pulso_presion[i] SHALL be registered and high for exactly the one cycle in which nivel[i] first reads 1 after the CONFIRMA_PRESION->PRESIONADO transition; pulso_liberacion[i] likewise on CONFIRMA_LIBERACION->SUELTO.
REQ-018 Latency: with botones_n[i] first sampled low at edge k and held, pulso_presion[i] and nivel[i] SHALL rise after edge k+2+DEBOUNCE_CICLOS; release symmetric.
REQ-019 Any glitch shorter than DEBOUNCE_CICLOS synchronized cycles SHALL produce no pulse and no nivel change.
REQ-020 Counter SHALL never exceed DEBOUNCE_CICLOS-1; no wrap-around.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce pulses in the same cycle when timing is equal.
REQ-022 pulso_presion[i] and pulso_liberacion[i] SHALL never be high in the same cycle; at most one pulse per channel per accepted transition.

Reset
REQ-023 rst=1 at a rising edge SHALL force synchronizer flops to 1, all FSMs to SUELTO, all counters to 0, and nivel, pulso_presion, pulso_liberacion to 0 on the next cycle.
REQ-024 Reset SHALL take priority over all other inputs, including mid-debounce and mid-pulse.
REQ-025 A button held low through reset release SHALL be re-qualified from SUELTO: one pulso_presion after the full REQ-018 latency measured from the first post-reset edge.

Verification (DEBOUNCE_CICLOS=4, N_BOTONES=3)
REQ-026 Clean press: botones_n[0] 1->0 held 20 cycles -> pulso_presion=3'b001 for one cycle exactly 6 edges after first low sample; nivel[0]=1 from same cycle.
REQ-027 Bounce reject: botones_n[1] low 3 cycles, high 1, low 3, high -> pulso_presion and nivel stay 3'b000 throughout.
REQ-028 Release: after accepted press on channel 2, botones_n[2] 0->1 held -> pulso_liberacion=3'b100 one cycle, 6 edges after first high sample; nivel[2]=0 same cycle.
REQ-029 Simultaneous: botones_n=3'b000 from 3'b111 on same edge -> pulso_presion=3'b111 for one cycle, then 3'b000; nivel=3'b111.
REQ-030 Reset mid-debounce: channel 0 in CONFIRMA_PRESION with counter=2, assert rst 1 cycle while held low -> all outputs 0 next cycle; pulso_presion[0] appears 6 edges after rst deassert.

Source files
------------

// File: rtl/acondicionador_botones.sv
// Push-button conditioner: per-channel two-flop synchronizer followed by an
// independent debounce FSM. Each FSM produces a registered debounced level
// and one-cycle pulses for every accepted press and release. Buttons are
// active-low at the pins; all outputs are active-high.
module acondicionador_botones #(
    parameter int N_BOTONES       = 3,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BOTONES-1:0] botones_n,
    output logic [N_BOTONES-1:0] nivel,
    output logic [N_BOTONES-1:0] pulso_presion,
    output logic [N_BOTONES-1:0] pulso_liberacion
);

    // One extra bit beyond the bits needed for DEBOUNCE_CICLOS-1 keeps the
    // counter comfortably wide at every legal parameter value.
    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CUENTA_MAX  = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CUENTA_UNO  = CW'(1);
    localparam logic [CW-1:0] CUENTA_CERO = CW'(0);

    typedef enum logic [1:0] {
        SUELTO              = 2'b00,
        CONFIRMA_PRESION    = 2'b01,
        PRESIONADO          = 2'b10,
        CONFIRMA_LIBERACION = 2'b11
    } estado_t;

    logic [N_BOTONES-1:0] sync1_r;
    logic [N_BOTONES-1:0] sync2_r;

    // Two-flop synchronizer; reset parks it at the released (high) level so
    // a button held through reset is re-qualified from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {N_BOTONES{1'b1}};
            sync2_r <= {N_BOTONES{1'b1}};
        end else begin
            sync1_r <= botones_n;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
        estado_t        estado_r;
        estado_t        estado_sig_s;
        logic [CW-1:0]  cuenta_r;
        logic [CW-1:0]  cuenta_sig_s;
        logic           s_s;
        logic           nivel_r;
        logic           presion_r;
        logic           liberacion_r;
        logic           nivel_sig_s;
        logic           presion_sig_s;
        logic           liberacion_sig_s;

        assign s_s = sync2_r[i];

        // State and counter register for this channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                estado_r <= SUELTO;
                cuenta_r <= CUENTA_CERO;
            end else begin
                estado_r <= estado_sig_s;
                cuenta_r <= cuenta_sig_s;
            end
        end

        // Next-state logic: a level change is accepted only after it has been
        // seen on DEBOUNCE_CICLOS consecutive synchronized samples; the
        // counter stops at CUENTA_MAX because the transition fires there.
        always_comb begin
            estado_sig_s = estado_r;
            cuenta_sig_s = cuenta_r;
            case (estado_r)
                SUELTO: begin
                    if (s_s == 1'b0) begin
                        estado_sig_s = CONFIRMA_PRESION;
                        cuenta_sig_s = CUENTA_UNO;
                    end else begin
                        estado_sig_s = SUELTO;
                        cuenta_sig_s = CUENTA_CERO;
                    end
                end
                CONFIRMA_PRESION: begin
                    if (s_s == 1'b1) begin
                        estado_sig_s = SUELTO;
                        cuenta_sig_s = CUENTA_CERO;
                    end else if (cuenta_r >= CUENTA_MAX) begin
                        estado_sig_s = PRESIONADO;
                        cuenta_sig_s = CUENTA_CERO;
                    end else begin
                        estado_sig_s = CONFIRMA_PRESION;
                        cuenta_sig_s = cuenta_r + CUENTA_UNO;
                    end
                end
                PRESIONADO: begin
                    if (s_s == 1'b1) begin
                        estado_sig_s = CONFIRMA_LIBERACION;
                        cuenta_sig_s = CUENTA_UNO;
                    end else begin
                        estado_sig_s = PRESIONADO;
                        cuenta_sig_s = CUENTA_CERO;
                    end
                end
                CONFIRMA_LIBERACION: begin
                    if (s_s == 1'b0) begin
                        estado_sig_s = PRESIONADO;
                        cuenta_sig_s = CUENTA_CERO;
                    end else if (cuenta_r >= CUENTA_MAX) begin
                        estado_sig_s = SUELTO;
                        cuenta_sig_s = CUENTA_CERO;
                    end else begin
                        estado_sig_s = CONFIRMA_LIBERACION;
                        cuenta_sig_s = cuenta_r + CUENTA_UNO;
                    end
                end
                default: begin
                    estado_sig_s = SUELTO;
                    cuenta_sig_s = CUENTA_CERO;
                end
            endcase
        end

        // Output decode: level follows the accepted state; a pulse fires on
        // the single cycle where the registered level is about to change.
        always_comb begin
            nivel_sig_s      = 1'b0;
            presion_sig_s    = 1'b0;
            liberacion_sig_s = 1'b0;
            case (estado_r)
                PRESIONADO: begin
                    nivel_sig_s   = 1'b1;
                    presion_sig_s = ~nivel_r;
                end
                CONFIRMA_LIBERACION: begin
                    nivel_sig_s = 1'b1;
                end
                SUELTO: begin
                    liberacion_sig_s = nivel_r;
                end
                CONFIRMA_PRESION: begin
                    nivel_sig_s = 1'b0;
                end
                default: begin
                    nivel_sig_s = 1'b0;
                end
            endcase
        end

        // Registered outputs for this channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                nivel_r      <= 1'b0;
                presion_r    <= 1'b0;
                liberacion_r <= 1'b0;
            end else begin
                nivel_r      <= nivel_sig_s;
                presion_r    <= presion_sig_s;
                liberacion_r <= liberacion_sig_s;
            end
        end

        assign nivel[i]            = nivel_r;
        assign pulso_presion[i]    = presion_r;
        assign pulso_liberacion[i] = liberacion_r;
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones with DEBOUNCE_CICLOS=4, N_BOTONES=3.
// Reference model: debounced level flips once the synchronized input has
// disagreed with it for D consecutive samples; outputs are that level
// delayed one register, pulses are its edges.
module tb_acondicionador_botones;

    localparam int N = 3;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] botones_n;
    logic [N-1:0] nivel;
    logic [N-1:0] pulso_presion;
    logic [N-1:0] pulso_liberacion;

    int tests;
    int fails;

    // model state
    logic [N-1:0] m_s1, m_s2, m_lvl, m_niv, m_pp, m_pl;
    int           m_run [N];

    acondicionador_botones #(.N_BOTONES(N), .DEBOUNCE_CICLOS(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .botones_n        (botones_n),
        .nivel            (nivel),
        .pulso_presion    (pulso_presion),
        .pulso_liberacion (pulso_liberacion)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the values sampled there.
    task automatic model_step(input logic [N-1:0] b, input logic r);
        logic [N-1:0] old_lvl;
        logic [N-1:0] old_niv;
        if (r) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '0; m_niv = '0; m_pp = '0; m_pl = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            old_lvl = m_lvl;
            old_niv = m_niv;
            m_niv = old_lvl;
            m_pp  = old_lvl & ~old_niv;
            m_pl  = ~old_lvl & old_niv;
            for (int c = 0; c < N; c++) begin
                // pressed when synchronized pin is 0
                if ((~m_s2[c]) != old_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_lvl[c] = ~old_lvl[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic tick(input logic [N-1:0] b, input logic r);
        botones_n = b;
        rst       = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check("nivel", nivel, m_niv);
        check("pulso_presion", pulso_presion, m_pp);
        check("pulso_liberacion", pulso_liberacion, m_pl);
        check("pulsos_exclusivos", pulso_presion & pulso_liberacion, 3'b000);
    endtask

    initial begin
        logic [N-1:0] b;
        int           hold [N];
        tests = 0;
        fails = 0;
        m_s1 = '1; m_s2 = '1; m_lvl = '0; m_niv = '0; m_pp = '0; m_pl = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        botones_n = 3'b111;
        rst = 1'b1;

        // reset state
        repeat (3) tick(3'b111, 1'b1);
        check("reset_nivel", nivel, 3'b000);
        check("reset_pp", pulso_presion, 3'b000);
        check("reset_pl", pulso_liberacion, 3'b000);
        repeat (3) tick(3'b111, 1'b0);

        // clean press on channel 0: first low sample at edge k, pulse after k+6
        tick(3'b110, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick(3'b110, 1'b0);
            check("press0_early", pulso_presion, 3'b000);
        end
        tick(3'b110, 1'b0);
        check("press0_pulse", pulso_presion, 3'b001);
        check("press0_nivel", nivel, 3'b001);
        tick(3'b110, 1'b0);
        check("press0_one_cycle", pulso_presion, 3'b000);
        check("press0_nivel_hold", nivel, 3'b001);
        repeat (12) tick(3'b110, 1'b0);
        repeat (10) tick(3'b111, 1'b0);
        check("release0_nivel", nivel, 3'b000);

        // bounce on channel 1 must be rejected
        repeat (3) begin tick(3'b101, 1'b0); check("bounce_pp", pulso_presion, 3'b000); check("bounce_nivel", nivel, 3'b000); end
        tick(3'b111, 1'b0);
        check("bounce_pp", pulso_presion, 3'b000);
        repeat (3) begin tick(3'b101, 1'b0); check("bounce_pp", pulso_presion, 3'b000); check("bounce_nivel", nivel, 3'b000); end
        repeat (10) begin tick(3'b111, 1'b0); check("bounce_pp", pulso_presion, 3'b000); check("bounce_nivel", nivel, 3'b000); end

        // release on channel 2
        repeat (12) tick(3'b011, 1'b0);
        check("press2_nivel", nivel, 3'b100);
        tick(3'b111, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick(3'b111, 1'b0);
            check("rel2_early", pulso_liberacion, 3'b000);
        end
        tick(3'b111, 1'b0);
        check("rel2_pulse", pulso_liberacion, 3'b100);
        check("rel2_nivel", nivel, 3'b000);
        tick(3'b111, 1'b0);
        check("rel2_one_cycle", pulso_liberacion, 3'b000);

        // simultaneous press on all channels
        tick(3'b000, 1'b0);
        repeat (5) tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
        check("simul_pulse", pulso_presion, 3'b111);
        check("simul_nivel", nivel, 3'b111);
        tick(3'b000, 1'b0);
        check("simul_one_cycle", pulso_presion, 3'b000);
        repeat (12) tick(3'b111, 1'b0);

        // reset mid-debounce: counter reaches 2 after edge k+3
        repeat (4) tick(3'b110, 1'b0);
        tick(3'b110, 1'b1);
        check("rst_mid_nivel", nivel, 3'b000);
        check("rst_mid_pp", pulso_presion, 3'b000);
        check("rst_mid_pl", pulso_liberacion, 3'b000);
        tick(3'b110, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick(3'b110, 1'b0);
            check("rst_requal_early", pulso_presion, 3'b000);
        end
        tick(3'b110, 1'b0);
        check("rst_requal_pulse", pulso_presion, 3'b001);
        repeat (10) tick(3'b111, 1'b0);

        // randomized stretches, varying hold lengths and occasional reset
        b = 3'b111;
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < N; c++) begin
                hold[c] = hold[c] - 1;
                if (hold[c] <= 0) begin
                    b[c] = ~b[c];
                    hold[c] = int'($urandom_range(1, 9));
                end
            end
            tick(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
